noc_mailbox: RTL
================

NOC_MAILBOX -- requirements
Module: noc_mailbox

Interface
REQ-001 Parameter ADDR_W, default 8, width of message address (destination/channel tag).
REQ-002 Parameter DATA_W, default 32, width of message payload.
REQ-003 Parameter CHANNELS, default 4, number of receive channels; power of two, 2..16.
REQ-004 Parameter DEPTH, default 8, entries per FIFO (TX and each RX); power of two, 2..64.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 cpu_tx_valid  in  1  CPU offers a message; cpu_tx_addr  in  ADDR_W; cpu_tx_data  in  DATA_W.
REQ-008 cpu_tx_ready  out  1  TX FIFO can accept a message.
REQ-009 noc_tx_valid  out  1  head message valid; noc_tx_addr  out  ADDR_W; noc_tx_data  out  DATA_W.
REQ-010 noc_tx_ready  in  1  link accepts the head message.
REQ-011 noc_rx_valid  in  1  incoming message strobe (no backpressure); noc_rx_addr  in  ADDR_W; noc_rx_data  in  DATA_W.
REQ-012 cpu_rx_ch  in  log2(CHANNELS)  channel selected for read; cpu_rx_pop  in  1  pop the selected channel's head.
REQ-013 cpu_rx_addr  out  ADDR_W; cpu_rx_data  out  DATA_W  head of the selected channel.
REQ-014 cpu_rx_nonempty  out  CHANNELS  bit i set when channel i holds at least one message.
REQ-015 rx_drop_cnt  out  16  count of dropped incoming messages.

Function
REQ-016 TX path: a DEPTH-entry first-word-fall-through FIFO; push when cpu_tx_valid and cpu_tx_ready, pop when noc_tx_valid and noc_tx_ready.
REQ-017 cpu_tx_ready = TX FIFO not full; noc_tx_valid = TX FIFO not empty; noc_tx_addr/data are driven from the head entry, and are zero when empty.
REQ-018 TX latency: a message pushed in cycle N appears on noc_tx in cycle N+1 if the FIFO was empty.
REQ-019 TX full with a simultaneous pop: cpu_tx_ready stays low that cycle; no push occurs.
REQ-020 TX empty with a simultaneous push: no pop occurs; noc_tx_valid rises the next cycle.
REQ-021 RX demux: channel = noc_rx_addr[log2(CHANNELS)-1:0]; address and data are stored together in that channel's FIFO.
REQ-022 RX push to a full channel is dropped unless that channel is popped in the same cycle, in which case the push is accepted.
REQ-023 A dropped message increments rx_drop_cnt by 1; the counter saturates at 0xFFFF.
REQ-024 cpu_rx_addr/data are driven combinationally from the head of channel cpu_rx_ch, and are zero when that channel is empty.
REQ-025 cpu_rx_pop on an empty channel is ignored, with no pointer change.
REQ-026 Pointers wrap modulo DEPTH; each FIFO keeps an occupancy counter 0..DEPTH that distinguishes full from empty.
REQ-027 Ordering: strict FIFO order within each channel and within TX; channels are independent.

Reset
REQ-028 While reset_n is low: all FIFOs are empty, cpu_tx_ready=1, noc_tx_valid=0, cpu_rx_nonempty=0, rx_drop_cnt=0, and data outputs are 0.
REQ-029 Reset asserted mid-transfer discards all buffered messages; there is no partial state after release.
REQ-030 Reset deassertion takes effect on the first clk edge after release, with no pushes on that edge.

Configuration
REQ-031 Macro NOC_MAILBOX_DROP_CNT_EN: when defined, rx_drop_cnt behaves per REQ-023.
REQ-032 When NOC_MAILBOX_DROP_CNT_EN is undefined, the counter logic is absent, rx_drop_cnt is tied to 0, and drop behaviour is otherwise unchanged.

Structure
REQ-033 Package noc_mailbox_pkg holds the message struct typedef (addr, data), the DROP_CNT_W=16 constant, and a channel-index width function.
REQ-034 One sub-module, mbox_fifo (parametrised width/depth, FWFT, occupancy count), is instantiated once for TX and CHANNELS times for RX.

Verification
REQ-035 After reset, push 8 messages with noc_tx_ready=0: the 9th cycle shows cpu_tx_ready=0; then raise ready and check all 8 emerge in order, one per cycle.
REQ-036 Drive noc_rx with addr 0x01, 0x05, 0x02 (CHANNELS=4): channel 1 holds 0x01 then 0x05, channel 2 holds 0x02, cpu_rx_nonempty=4'b0110.
REQ-037 Fill channel 3 (8 messages), then send a 9th to it: it is dropped and rx_drop_cnt=1; a 9th sent with a same-cycle pop is accepted and count stays 1.
REQ-038 Force 65540 drops: rx_drop_cnt holds 0xFFFF; without the macro it reads 0 throughout.
REQ-039 Pop empty channel 0: no output change and no underflow; assert reset_n low with data in all FIFOs and check every REQ-028 value.

Source files
------------

// File: rtl/noc_mailbox_pkg.sv
// noc_mailbox_pkg -- shared types and constants for the NoC mailbox.
//   msg_t       : message record (address tag + payload) at the default widths
//   DROP_CNT_W  : width of the saturating dropped-message counter
//   ch_idx_w()  : width of a channel index for a given channel count
package noc_mailbox_pkg;

    localparam int MSG_ADDR_W = 8;
    localparam int MSG_DATA_W = 32;
    localparam int DROP_CNT_W = 16;

    typedef struct packed {
        logic [MSG_ADDR_W-1:0] addr;
        logic [MSG_DATA_W-1:0] data;
    } msg_t;

    // A single channel still needs a one-bit select so ports never collapse to zero width.
    function automatic int ch_idx_w(input int channels);
        if (channels > 1) begin
            return $clog2(channels);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/mbox_fifo.sv
// mbox_fifo -- first-word-fall-through FIFO with an occupancy counter.
//   clk, reset_n : clock, asynchronous active-low reset
//   push_i/wdata_i : write request and data; accepted when not full, or when
//                    full and a pop happens in the same cycle
//   pop_i          : read request; ignored when empty
//   rdata_o        : head entry, zero while empty
//   full_o/empty_o : occupancy flags derived from the counter (0..DEPTH)
module mbox_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_fire_s;
    logic             pop_fire_s;

    // Handshake qualification, pointer advance and occupancy update.
    always_comb begin
        pop_fire_s  = pop_i && (count_q != {CNT_W{1'b0}});
        // A pop frees the slot this cycle, so a full FIFO may still take a push.
        push_fire_s = push_i && ((count_q != FULL_CNT) || pop_fire_s);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        // DEPTH is a power of two, so plain increment wraps modulo DEPTH.
        if (push_fire_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_fire_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_fire_s, pop_fire_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset: an empty FIFO never exposes it.
    always_ff @(posedge clk) begin
        if (push_fire_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign empty_o = (count_q == {CNT_W{1'b0}});
    assign full_o  = (count_q == FULL_CNT);
    assign rdata_o = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

endmodule

// File: rtl/noc_mailbox.sv
// noc_mailbox -- CPU <-> NoC mailbox: one TX FIFO toward the link and
// CHANNELS RX FIFOs demultiplexed by the low address bits of incoming messages.
//   cpu_tx_*   : CPU writes messages (valid/ready)
//   noc_tx_*   : head of TX FIFO toward the link (valid/ready)
//   noc_rx_*   : incoming message strobe, no backpressure; overflow is dropped
//   cpu_rx_*   : CPU reads the head of channel cpu_rx_ch, pops with cpu_rx_pop
//   cpu_rx_nonempty : per-channel occupancy flags
//   rx_drop_cnt     : saturating dropped-message counter
// Build option: define NOC_MAILBOX_DROP_CNT_EN to include the drop counter;
// otherwise rx_drop_cnt is tied to zero.
module noc_mailbox
    import noc_mailbox_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 8,
    localparam int CH_W    = ch_idx_w(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpu_tx_valid,
    input  logic [ADDR_W-1:0]     cpu_tx_addr,
    input  logic [DATA_W-1:0]     cpu_tx_data,
    output logic                  cpu_tx_ready,
    output logic                  noc_tx_valid,
    output logic [ADDR_W-1:0]     noc_tx_addr,
    output logic [DATA_W-1:0]     noc_tx_data,
    input  logic                  noc_tx_ready,
    input  logic                  noc_rx_valid,
    input  logic [ADDR_W-1:0]     noc_rx_addr,
    input  logic [DATA_W-1:0]     noc_rx_data,
    input  logic [CH_W-1:0]       cpu_rx_ch,
    input  logic                  cpu_rx_pop,
    output logic [ADDR_W-1:0]     cpu_rx_addr,
    output logic [DATA_W-1:0]     cpu_rx_data,
    output logic [CHANNELS-1:0]   cpu_rx_nonempty,
    output logic [DROP_CNT_W-1:0] rx_drop_cnt
);

    localparam int MSG_W = ADDR_W + DATA_W;

    logic             tx_full_s;
    logic             tx_empty_s;
    logic             tx_push_s;
    logic [MSG_W-1:0] tx_head_s;
    logic [CH_W-1:0]  rx_ch_s;
    logic [CHANNELS-1:0] rx_full_s;
    logic [CHANNELS-1:0] rx_empty_s;
    logic [MSG_W-1:0] rx_head_s [CHANNELS];

    // TX ready reflects full only; a same-cycle pop does not open a slot.
    assign tx_push_s    = cpu_tx_valid && !tx_full_s;
    assign cpu_tx_ready = !tx_full_s;
    assign noc_tx_valid = !tx_empty_s;
    assign {noc_tx_addr, noc_tx_data} = tx_head_s;

    mbox_fifo #(.WIDTH(MSG_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (tx_push_s),
        .wdata_i ({cpu_tx_addr, cpu_tx_data}),
        .pop_i   (noc_tx_ready),
        .rdata_o (tx_head_s),
        .full_o  (tx_full_s),
        .empty_o (tx_empty_s)
    );

    assign rx_ch_s = noc_rx_addr[CH_W-1:0];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_rx
        mbox_fifo #(.WIDTH(MSG_W), .DEPTH(DEPTH)) u_rx_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push_i  (noc_rx_valid && (rx_ch_s == CH_W'(g))),
            .wdata_i ({noc_rx_addr, noc_rx_data}),
            .pop_i   (cpu_rx_pop && (cpu_rx_ch == CH_W'(g))),
            .rdata_o (rx_head_s[g]),
            .full_o  (rx_full_s[g]),
            .empty_o (rx_empty_s[g])
        );
    end

    assign cpu_rx_nonempty = ~rx_empty_s;
    assign {cpu_rx_addr, cpu_rx_data} = rx_head_s[cpu_rx_ch];

`ifdef NOC_MAILBOX_DROP_CNT_EN
    localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};

    logic                  drop_s;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // A message is lost only when its channel is full and not popped this cycle.
    always_comb begin
        drop_s = noc_rx_valid && rx_full_s[rx_ch_s]
                 && !(cpu_rx_pop && (cpu_rx_ch == rx_ch_s));
        if (drop_s && (drop_cnt_q != DROP_MAX)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Saturating drop counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= {DROP_CNT_W{1'b0}};
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign rx_drop_cnt = drop_cnt_q;
`else
    assign rx_drop_cnt = {DROP_CNT_W{1'b0}};
`endif

endmodule
